// File: rtl/vdec_tb_gen.sv
// vdec_tb_gen: parametrised Viterbi backward-traceback engine over the pointer RAM.
// Optional macro VDEC_TB_FINAL_STATE_EN adds the final_state / state_err outputs.
`default_nettype none
module vdec_tb_gen #(
  parameter int STATE_W = 8,
  parameter int PT_DW   = 32,
  parameter int MAX_BLK = 29,
  parameter int TAIL    = 8,
  localparam int BSEL_W = $clog2(PT_DW),
  localparam int WSEL_W = STATE_W - BSEL_W,
  localparam int STG_W  = $clog2(MAX_BLK + TAIL),
  localparam int ADDR_W = STG_W + WSEL_W,
  localparam int LEN_W  = $clog2(MAX_BLK + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   blk_len,
  input  logic               tb_mode,
  input  logic [STATE_W-1:0] start_state,
  output logic               busy,
  output logic               done,
  output logic               len_err,
  output logic [MAX_BLK-1:0] dec_bits,
  output logic               pt_rd,
  output logic [ADDR_W-1:0]  pt_addr,
  input  logic [PT_DW-1:0]   pt_dout
`ifdef VDEC_TB_FINAL_STATE_EN
  ,
  output logic [STATE_W-1:0] final_state,
  output logic               state_err
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_CAPT  = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]         state, state_nxt;
  logic [STG_W-1:0]   stage, stage_nxt;
  logic [STATE_W-1:0] cur_state, cur_state_nxt;
  logic [LEN_W-1:0]   len_q, len_nxt;
  logic [MAX_BLK-1:0] shreg, shreg_nxt;
  logic               len_ok, dec_bit, load_start, last_capt;
  logic               busy_nxt, done_nxt, len_err_nxt, pt_rd_nxt;
  logic [ADDR_W-1:0]  pt_addr_nxt;

  assign len_ok  = (blk_len != '0) && (int'(blk_len) <= MAX_BLK);
  assign dec_bit = pt_dout[cur_state[BSEL_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = len_ok ? S_ISSUE : S_FIN;
      S_ISSUE: state_nxt = S_CAPT;
      S_CAPT:  state_nxt = (stage == '0) ? S_FIN : S_ISSUE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    stage_nxt     = stage;
    cur_state_nxt = cur_state;
    len_nxt       = len_q;
    shreg_nxt     = shreg;
    load_start    = (state == S_IDLE) && start && len_ok;
    last_capt     = (state == S_CAPT) && (stage == '0);
    if (load_start) begin
      len_nxt       = blk_len;
      stage_nxt     = STG_W'(blk_len) + STG_W'(TAIL - 1);
      cur_state_nxt = tb_mode ? start_state : '0;
      shreg_nxt     = '0;
    end
    if (state == S_CAPT) begin
      // Traceback step: the decision bit becomes the MSB of the predecessor state.
      cur_state_nxt = {dec_bit, cur_state[STATE_W-1:1]};
      if (int'(stage) < int'(len_q)) shreg_nxt = {shreg[MAX_BLK-2:0], dec_bit};
      if (stage != '0) stage_nxt = stage - STG_W'(1);
    end
    busy_nxt    = (state_nxt == S_ISSUE) || (state_nxt == S_CAPT);
    pt_rd_nxt   = (state_nxt == S_ISSUE);
    pt_addr_nxt = pt_rd_nxt ? {stage_nxt, cur_state_nxt[STATE_W-1 -: WSEL_W]} : pt_addr;
    done_nxt    = (state_nxt == S_FIN);
    len_err_nxt = (state == S_IDLE) && (state_nxt == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage     <= '0;
      cur_state <= '0;
      len_q     <= '0;
      shreg     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      len_err   <= 1'b0;
      dec_bits  <= '0;
      pt_rd     <= 1'b0;
      pt_addr   <= '0;
    end else begin
      stage     <= stage_nxt;
      cur_state <= cur_state_nxt;
      len_q     <= len_nxt;
      shreg     <= shreg_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      len_err   <= len_err_nxt;
      pt_rd     <= pt_rd_nxt;
      pt_addr   <= pt_addr_nxt;
      if (last_capt) dec_bits <= shreg_nxt;
    end
  end

`ifdef VDEC_TB_FINAL_STATE_EN
  logic mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= 1'b0;
      final_state <= '0;
      state_err   <= 1'b0;
    end else begin
      if (load_start) mode_q <= tb_mode;
      if (last_capt) final_state <= cur_state_nxt;
      state_err <= last_capt && !mode_q && (cur_state_nxt != '0);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vdec_tb_gen.sv
// Self-checking bench for vdec_tb_gen: vector table, golden encoder path, random blocks.
`default_nettype none
module tb_vdec_tb_gen;
  localparam int ADDR_W = 9;

  logic        clk = 1'b0;
  logic        rst, start, tb_mode;
  logic [4:0]  blk_len;
  logic [7:0]  start_state;
  logic        busy, done, len_err, pt_rd;
  logic [28:0] dec_bits;
  logic [8:0]  pt_addr;
  logic [31:0] pt_dout;
`ifdef VDEC_TB_FINAL_STATE_EN
  logic [7:0]  final_state;
  logic        state_err;
`endif

  vdec_tb_gen dut (
    .clk(clk), .rst(rst), .start(start), .blk_len(blk_len), .tb_mode(tb_mode),
    .start_state(start_state), .busy(busy), .done(done), .len_err(len_err),
    .dec_bits(dec_bits), .pt_rd(pt_rd), .pt_addr(pt_addr), .pt_dout(pt_dout)
`ifdef VDEC_TB_FINAL_STATE_EN
    , .final_state(final_state), .state_err(state_err)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0]       ram [0:511];
  logic [31:0]       rdata;
  int                rd_count = 0;
  logic [ADDR_W-1:0] addr_log [0:4095];
  assign pt_dout = rdata;

  always @(posedge clk) begin
    if (pt_rd) begin
      rdata <= ram[pt_addr];
      addr_log[rd_count % 4096] <= pt_addr;
      rd_count <= rd_count + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [28:0] prev_dec = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_ram(input int kind);
    for (int a = 0; a < 512; a++)
      ram[a] = (kind == 0) ? 32'h0 : (kind == 1) ? 32'hFFFF_FFFF : $urandom;
  endtask

  // Reference traceback: walk the trellis backwards from the start state.
  task automatic model(input logic [4:0] len, input logic mode, input logic [7:0] ss,
                       output logic [28:0] dec, output logic [7:0] fin);
    logic [7:0]  st;
    logic [31:0] w;
    logic        d;
    st  = mode ? ss : 8'h00;
    dec = '0;
    for (int s = int'(len) + 7; s >= 0; s--) begin
      w  = ram[s * 8 + int'(st) / 32];
      d  = w[int'(st) % 32];
      st = 8'((int'(st) / 2) + (int'(d) * 128));
      if (s < int'(len)) dec[s] = d;
    end
    fin = st;
  endtask

  // Runs one block and checks timing, read count, flags and results.
  task automatic run_block(input string tag, input logic [4:0] len, input logic mode,
                           input logic [7:0] ss, input int inject,
                           input logic [28:0] exp_dec, input logic [7:0] exp_fin,
                           output int base, output int nreads);
    int  cyc, bcnt, n;
    logic err;
    err = (len == 0) || (len > 29);
    n   = int'(len) + 8;
    @(negedge clk);
    blk_len = len; tb_mode = mode; start_state = ss; start = 1'b1;
    base = rd_count;
    @(negedge clk);
    start = 1'b0; blk_len = 5'($urandom); tb_mode = 1'($urandom); start_state = 8'($urandom);
    cyc = 1; bcnt = 0;
    while (done !== 1'b1 && cyc < 300) begin
      if (busy === 1'b1) bcnt++;
      start = (cyc == inject);
      @(negedge clk);
      cyc++;
    end
    start  = 1'b0;
    nreads = rd_count - base;
    chk({tag, ".done_cycle"}, cyc, err ? 1 : 2 * n + 1);
    chk({tag, ".busy_cycles"}, bcnt, err ? 0 : 2 * n);
    chk({tag, ".reads"}, nreads, err ? 0 : n);
    chk({tag, ".len_err"}, len_err, err);
    chk({tag, ".busy_at_done"}, busy, 0);
    chk({tag, ".dec_bits"}, dec_bits, err ? prev_dec : exp_dec);
`ifdef VDEC_TB_FINAL_STATE_EN
    if (!err) begin
      chk({tag, ".final_state"}, final_state, exp_fin);
      chk({tag, ".state_err"}, state_err, (!mode) && (exp_fin != 0));
    end
`endif
    if (!err) prev_dec = exp_dec;
    @(negedge clk);
    chk({tag, ".done_pulse"}, {done, len_err}, 2'b00);
  endtask

  typedef struct {
    logic [4:0]  len;
    logic        mode;
    logic [7:0]  ss;
    int          fill;
    logic [28:0] exp_dec;
    logic [7:0]  exp_fin;
    logic [8:0]  addr_first;
    logic [8:0]  addr_last;
  } vec_t;

  initial begin
    vec_t        vecs [6];
    logic [28:0] dec, info;
    logic [7:0]  fin, t, ss;
    logic        u [0:44];
    logic [4:0]  len;
    logic        mode;
    int          base, nr, saw_done;

    vecs[0] = '{5'd29, 1'b0, 8'h00, 0, 29'h0,        8'h00, {6'd36, 3'd0}, 9'h000};
    vecs[1] = '{5'd1,  1'b1, 8'hA5, 1, 29'h1,        8'hFF, {6'd8, 3'd5},  9'h007};
    vecs[2] = '{5'd0,  1'b0, 8'h00, 1, 29'h0,        8'h00, 9'h000,        9'h000};
    vecs[3] = '{5'd30, 1'b1, 8'h11, 1, 29'h0,        8'h00, 9'h000,        9'h000};
    vecs[4] = '{5'd29, 1'b0, 8'h00, 1, 29'h1FFFFFFF, 8'hFF, {6'd36, 3'd0}, 9'h007};
    vecs[5] = '{5'd5,  1'b1, 8'h3C, 0, 29'h0,        8'h00, {6'd12, 3'd1}, 9'h000};

    rst = 1'b1; start = 1'b0; blk_len = '0; tb_mode = 1'b0; start_state = '0;
    fill_ram(0);
    repeat (3) @(negedge clk);
    chk("reset.outputs", {busy, done, len_err, pt_rd}, 4'b0000);
    chk("reset.dec_bits", dec_bits, 0);
    chk("reset.pt_addr", pt_addr, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      fill_ram(vecs[i].fill);
      run_block($sformatf("vec%0d", i), vecs[i].len, vecs[i].mode, vecs[i].ss, -1,
                vecs[i].exp_dec, vecs[i].exp_fin, base, nr);
      if (vecs[i].len != 0 && vecs[i].len <= 29) begin
        chk($sformatf("vec%0d.addr_first", i), addr_log[base % 4096], vecs[i].addr_first);
        chk($sformatf("vec%0d.addr_last", i), addr_log[(base + nr - 1) % 4096], vecs[i].addr_last);
      end
    end

    // Encoder survivor path: row r holds state {u[r+1]..u[r+8]} whose decision is u[r].
    fill_ram(2);
    info = 29'($urandom);
    for (int k = 0; k < 45; k++) u[k] = (k < 29) ? info[k] : 1'b0;
    for (int r = 0; r < 37; r++) begin
      t = '0;
      for (int k = 1; k <= 8; k++) t = {t[6:0], u[r + k]};
      ram[r * 8 + int'(t[7:5])][t[4:0]] = u[r];
    end
    model(5'd29, 1'b0, 8'h00, dec, fin);
    chk("golden.model_vs_info", dec, info);
    run_block("golden", 5'd29, 1'b0, 8'h00, -1, info, fin, base, nr);

    // A second start mid-block must not disturb the running traceback.
    fill_ram(2);
    model(5'd29, 1'b0, 8'h00, dec, fin);
    run_block("restart", 5'd29, 1'b0, 8'h00, 10, dec, fin, base, nr);

    for (int i = 0; i < 8; i++) begin
      fill_ram(2);
      len  = 5'($urandom_range(1, 29));
      mode = 1'($urandom);
      ss   = 8'($urandom);
      model(len, mode, ss, dec, fin);
      run_block($sformatf("rand%0d", i), len, mode, ss, -1, dec, fin, base, nr);
    end

    // Abort by reset at cycle 20.
    fill_ram(2);
    @(negedge clk);
    blk_len = 5'd29; tb_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("abort.busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort.outputs", {busy, pt_rd, done, len_err}, 4'b0000);
    chk("abort.dec_bits", dec_bits, 0);
    rst = 1'b0;
    prev_dec = '0;
    saw_done = 0;
    repeat (80) begin
      @(negedge clk);
      if (done === 1'b1) saw_done++;
    end
    chk("abort.no_done", saw_done, 0);
    model(5'd17, 1'b1, 8'h5A, dec, fin);
    run_block("after_abort", 5'd17, 1'b1, 8'h5A, -1, dec, fin, base, nr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
